// File: rtl/ttl_latch_pkg.sv
// rtl/ttl_latch_pkg.sv - shared types and LFSR constants for the R-S latch bank
package ttl_latch_pkg;

    // Output policy while both latch inputs are asserted together.
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SET_DOM  = 2'd1,
        RST_DOM  = 2'd2,
        NOR_TRUE = 2'd3
    } illegal_policy_e;

    // How a simultaneous release of both inputs is resolved.
    typedef enum logic {
        RACE_HOLD = 1'b0,
        RACE_RAND = 1'b1
    } race_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/rsff_chan.sv
// rtl/rsff_chan.sv - one R-S latch channel with filter, illegal policy, race resolution and edge pulses
module rsff_chan
    import ttl_latch_pkg::*;
#(
    parameter int   ACTIVE_LOW = 0,
    parameter int   ILLEGAL    = 0,
    parameter int   RACE_MODE  = 0,
    parameter int   FILT       = 0,
    parameter logic INIT       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_r,
    input  logic i_s,
    input  logic i_lfsr_bit,
    output logic o_q,
    output logic o_q_n,
    output logic o_rise,
    output logic o_fall,
    output logic o_race
);

    localparam illegal_policy_e POLICY = illegal_policy_e'(ILLEGAL[1:0]);
    localparam race_mode_e      RMODE  = race_mode_e'(RACE_MODE[0]);

    // Bit 1 carries set, bit 0 carries reset; both normalised to active-high.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic       w_rf, w_sf, w_both, w_q, w_q_n, w_race, w_dq_next;
    logic       r_dq, r_prev_both, r_qd, r_rise, r_fall, r_race;

    assign w_raw = {i_s, i_r} ^ {2{ACTIVE_LOW[0]}};

    generate
        if (FILT == 0) begin : g_bypass
            assign w_filt = w_raw;
        end else begin : g_filt
            for (genvar b = 0; b < 2; b++) begin : g_bit
                logic       r_f;
                logic [3:0] r_cnt;
                // Accept a new input level only after it has held for FILT samples.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_f   <= 1'b0;
                        r_cnt <= 4'd0;
                    end else if (w_raw[b] == r_f) begin
                        r_cnt <= 4'd0;
                    end else if (r_cnt == 4'(FILT - 1)) begin
                        r_f   <= w_raw[b];
                        r_cnt <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                assign w_filt[b] = r_f;
            end
        end
    endgenerate

    assign w_rf   = w_filt[0];
    assign w_sf   = w_filt[1];
    assign w_both = w_rf & w_sf;
    assign w_race = r_prev_both & ~w_rf & ~w_sf;

    // Latch output: a single asserted input wins, both asserted follows the policy.
    always_comb begin
        w_q = r_dq;
        if (w_rf ^ w_sf) begin
            w_q = w_sf;
        end else if (w_both) begin
            case (POLICY)
                HOLD:     w_q = r_dq;
                SET_DOM:  w_q = 1'b1;
                RST_DOM:  w_q = 1'b0;
                NOR_TRUE: w_q = 1'b0;
                default:  w_q = r_dq;
            endcase
        end
        w_q_n = ~w_q;
        if ((POLICY == NOR_TRUE) && w_both) begin
            w_q_n = 1'b0;
        end
    end

    // A simultaneous release keeps the stored bit or draws it from the LFSR.
    always_comb begin
        w_dq_next = w_q;
        if (w_race) begin
            w_dq_next = (RMODE == RACE_RAND) ? i_lfsr_bit : r_dq;
        end
    end

    // Stored state, race history and registered edge pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dq        <= INIT;
            r_prev_both <= 1'b0;
            r_qd        <= INIT;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_race      <= 1'b0;
        end else begin
            r_dq        <= w_dq_next;
            r_prev_both <= w_both;
            r_qd        <= w_q;
            r_rise      <= w_q & ~r_qd;
            r_fall      <= ~w_q & r_qd;
            r_race      <= w_race;
        end
    end

    assign o_q    = w_q;
    assign o_q_n  = w_q_n;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_race = r_race;

endmodule

// File: rtl/ttl_rsff_bank.sv
// rtl/ttl_rsff_bank.sv - bank of CH R-S latches sharing one drive clock and one LFSR
module ttl_rsff_bank
    import ttl_latch_pkg::*;
#(
    parameter int            CH         = 4,
    parameter int            ACTIVE_LOW = 0,
    parameter int            ILLEGAL    = 0,
    parameter int            RACE_MODE  = 0,
    parameter int            FILT       = 0,
    parameter logic [CH-1:0] INIT       = {CH{1'b0}}
) (
    input  logic          CLK_DRV,
    input  logic          RST_N,
    input  logic [CH-1:0] R,
    input  logic [CH-1:0] S,
    output logic [CH-1:0] Q,
    output logic [CH-1:0] Q_N,
    output logic [CH-1:0] Q_RISE,
    output logic [CH-1:0] Q_FALL,
    output logic [CH-1:0] RACE
);

    logic [15:0] r_lfsr;

    // Free-running race-resolution LFSR, advanced every drive clock.
    always_ff @(posedge CLK_DRV or negedge RST_N) begin
        if (!RST_N) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    generate
        for (genvar ch = 0; ch < CH; ch++) begin : g_chan
            rsff_chan #(
                .ACTIVE_LOW (ACTIVE_LOW),
                .ILLEGAL    (ILLEGAL),
                .RACE_MODE  (RACE_MODE),
                .FILT       (FILT),
                .INIT       (INIT[ch])
            ) u_chan (
                .i_clk      (CLK_DRV),
                .i_rst_n    (RST_N),
                .i_r        (R[ch]),
                .i_s        (S[ch]),
                .i_lfsr_bit (r_lfsr[ch % 16]),
                .o_q        (Q[ch]),
                .o_q_n      (Q_N[ch]),
                .o_rise     (Q_RISE[ch]),
                .o_fall     (Q_FALL[ch]),
                .o_race     (RACE[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ttl_rsff_bank.sv
// tb/tb_ttl_rsff_bank.sv - self-checking bench for ttl_rsff_bank
module tb_ttl_rsff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] r_in, s_in, rn_in, sn_in;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e;
    logic [15:0] ref_lfsr;

    logic [3:0] bq, bqn, brise, bfall, brace;
    logic [3:0] pq[4], pqn[4], prise[4], pfall[4], prace[4];
    logic [3:0] xq, xqn, xrise, xfall, xrace;
    logic [3:0] fq, fqn, frise, ffall, frace;
    logic [3:0] nq, nqn, nrise, nfall, nrace;

    always #5 clk = ~clk;

    ttl_rsff_bank #(.CH(4), .ACTIVE_LOW(0), .ILLEGAL(0), .RACE_MODE(0), .FILT(0), .INIT(4'b0101)) u_base (
        .CLK_DRV(clk), .RST_N(rst_n), .R(r_in), .S(s_in),
        .Q(bq), .Q_N(bqn), .Q_RISE(brise), .Q_FALL(bfall), .RACE(brace));

    for (genvar g = 0; g < 4; g++) begin : g_pol
        ttl_rsff_bank #(.CH(4), .ACTIVE_LOW(0), .ILLEGAL(g), .RACE_MODE(0), .FILT(0), .INIT(4'b0000)) u_pol (
            .CLK_DRV(clk), .RST_N(rst_n), .R(r_in), .S(s_in),
            .Q(pq[g]), .Q_N(pqn[g]), .Q_RISE(prise[g]), .Q_FALL(pfall[g]), .RACE(prace[g]));
    end

    ttl_rsff_bank #(.CH(4), .ACTIVE_LOW(0), .ILLEGAL(0), .RACE_MODE(1), .FILT(0), .INIT(4'b0000)) u_rnd (
        .CLK_DRV(clk), .RST_N(rst_n), .R(r_in), .S(s_in),
        .Q(xq), .Q_N(xqn), .Q_RISE(xrise), .Q_FALL(xfall), .RACE(xrace));

    ttl_rsff_bank #(.CH(4), .ACTIVE_LOW(0), .ILLEGAL(0), .RACE_MODE(0), .FILT(3), .INIT(4'b0101)) u_filt (
        .CLK_DRV(clk), .RST_N(rst_n), .R(r_in), .S(s_in),
        .Q(fq), .Q_N(fqn), .Q_RISE(frise), .Q_FALL(ffall), .RACE(frace));

    ttl_rsff_bank #(.CH(4), .ACTIVE_LOW(1), .ILLEGAL(0), .RACE_MODE(0), .FILT(0), .INIT(4'b0000)) u_nand (
        .CLK_DRV(clk), .RST_N(rst_n), .R(rn_in), .S(sn_in),
        .Q(nq), .Q_N(nqn), .Q_RISE(nrise), .Q_FALL(nfall), .RACE(nrace));

    // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting, seeded with ACE1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= 16'hACE1;
        else        ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r_in  = 4'h0;
        s_in  = 4'h0;
        rn_in = 4'hF;
        sn_in = 4'hF;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0000);
        #1;
        e = exp_q.pop_front(); checks++; if (bq !== e) begin errors++; $display("FAIL reset_q: got %b want %b", bq, e); end
        e = exp_q.pop_front(); checks++; if (bqn !== e) begin errors++; $display("FAIL reset_qn: got %b want %b", bqn, e); end
        e = exp_q.pop_front(); checks++; if ((brise | bfall | brace) !== e) begin errors++; $display("FAIL reset_pulses: got %b want %b", brise | bfall | brace, e); end
        rst_n = 1'b1;
        step();
        s_in = 4'b0010;
        exp_q.push_back(4'b0111);
        #1;
        e = exp_q.pop_front(); checks++; if (bq !== e) begin errors++; $display("FAIL set_same_cycle: got %b want %b", bq, e); end
        step();
        s_in = 4'b0000;
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0010);
        #1;
        e = exp_q.pop_front(); checks++; if (bq !== e) begin errors++; $display("FAIL set_held: got %b want %b", bq, e); end
        e = exp_q.pop_front(); checks++; if (brise !== e) begin errors++; $display("FAIL rise_pulse: got %b want %b", brise, e); end
        step();
        exp_q.push_back(4'b0000);
        e = exp_q.pop_front(); checks++; if (brise !== e) begin errors++; $display("FAIL rise_one_clk: got %b want %b", brise, e); end
        r_in = 4'b0010;
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b1010);
        #1;
        e = exp_q.pop_front(); checks++; if (bq !== e) begin errors++; $display("FAIL reset_input_q: got %b want %b", bq, e); end
        e = exp_q.pop_front(); checks++; if (bqn !== e) begin errors++; $display("FAIL reset_input_qn: got %b want %b", bqn, e); end
        step();
        r_in = 4'b0000;
        exp_q.push_back(4'b0010);
        #1;
        e = exp_q.pop_front(); checks++; if (bfall !== e) begin errors++; $display("FAIL fall_pulse: got %b want %b", bfall, e); end
    endtask

    task automatic test_policy_and_race_hold();
        logic [3:0] q_exp[4];
        logic [3:0] qn_exp[4];
        q_exp  = '{4'hF, 4'hF, 4'h0, 4'h0};
        qn_exp = '{4'h0, 4'h0, 4'hF, 4'h0};
        do_reset();
        rst_n = 1'b1;
        step();
        s_in = 4'hF;
        step();
        s_in = 4'h0;
        r_in = 4'hF;
        s_in = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(q_exp[k]);
            exp_q.push_back(qn_exp[k]);
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); checks++; if (pq[k] !== e) begin errors++; $display("FAIL policy%0d_q: got %b want %b", k, pq[k], e); end
            e = exp_q.pop_front(); checks++; if (pqn[k] !== e) begin errors++; $display("FAIL policy%0d_qn: got %b want %b", k, pqn[k], e); end
        end
        step();
        step();
        step();
        r_in = 4'h0;
        s_in = 4'h0;
        for (int k = 0; k < 4; k++) exp_q.push_back(q_exp[k]);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); checks++; if (pq[k] !== e) begin errors++; $display("FAIL release%0d_q: got %b want %b", k, pq[k], e); end
        end
        step();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(4'hF);
            exp_q.push_back(q_exp[k]);
        end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); checks++; if (prace[k] !== e) begin errors++; $display("FAIL race%0d_pulse: got %b want %b", k, prace[k], e); end
            e = exp_q.pop_front(); checks++; if (pq[k] !== e) begin errors++; $display("FAIL race%0d_kept_q: got %b want %b", k, pq[k], e); end
        end
        step();
        exp_q.push_back(4'h0);
        e = exp_q.pop_front(); checks++; if (prace[0] !== e) begin errors++; $display("FAIL race_one_clk: got %b want %b", prace[0], e); end
    endtask

    task automatic test_race_random();
        do_reset();
        rst_n = 1'b1;
        step();
        for (int it = 0; it < 3; it++) begin
            r_in = 4'hF;
            s_in = 4'hF;
            step();
            step();
            step();
            r_in = 4'h0;
            s_in = 4'h0;
            #1;
            exp_q.push_back(ref_lfsr[3:0]);
            step();
            e = exp_q.pop_front(); checks++; if (xq !== e) begin errors++; $display("FAIL race_rand%0d_q: got %b want %b", it, xq, e); end
            exp_q.push_back(4'hF);
            e = exp_q.pop_front(); checks++; if (xrace !== e) begin errors++; $display("FAIL race_rand%0d_pulse: got %b want %b", it, xrace, e); end
            step();
        end
    endtask

    task automatic test_filter();
        do_reset();
        rst_n = 1'b1;
        step();
        s_in = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) s_in = 4'b0000;
            exp_q.push_back(4'b0101);
            #1;
            e = exp_q.pop_front(); checks++; if (fq !== e) begin errors++; $display("FAIL filt_short%0d: got %b want %b", k, fq, e); end
            step();
        end
        s_in = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back((k == 3) ? 4'b0111 : 4'b0101);
            step();
            e = exp_q.pop_front(); checks++; if (fq !== e) begin errors++; $display("FAIL filt_long_edge%0d: got %b want %b", k, fq, e); end
        end
        s_in = 4'b0000;
        step();
        step();
        step();
        exp_q.push_back(4'b0111);
        e = exp_q.pop_front(); checks++; if (fq !== e) begin errors++; $display("FAIL filt_latched: got %b want %b", fq, e); end
    endtask

    task automatic test_async_reset_mid_filter();
        s_in = 4'b1000;
        step();
        step();
        rst_n = 1'b0;
        exp_q.push_back(4'b0101);
        #1;
        e = exp_q.pop_front(); checks++; if (fq !== e) begin errors++; $display("FAIL async_reset_q: got %b want %b", fq, e); end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back((k == 3) ? 4'b1101 : 4'b0101);
            step();
            e = exp_q.pop_front(); checks++; if (fq !== e) begin errors++; $display("FAIL post_reset_edge%0d: got %b want %b", k, fq, e); end
        end
        s_in = 4'b0000;
    endtask

    task automatic test_nand();
        do_reset();
        rst_n = 1'b1;
        step();
        sn_in = 4'b1110;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1110);
        #1;
        e = exp_q.pop_front(); checks++; if (nq !== e) begin errors++; $display("FAIL nand_set_q: got %b want %b", nq, e); end
        e = exp_q.pop_front(); checks++; if (nqn !== e) begin errors++; $display("FAIL nand_set_qn: got %b want %b", nqn, e); end
        step();
        sn_in = 4'b1111;
        exp_q.push_back(4'b0001);
        #1;
        e = exp_q.pop_front(); checks++; if (nq !== e) begin errors++; $display("FAIL nand_hold: got %b want %b", nq, e); end
        rn_in = 4'b1110;
        exp_q.push_back(4'b0000);
        #1;
        e = exp_q.pop_front(); checks++; if (nq !== e) begin errors++; $display("FAIL nand_reset: got %b want %b", nq, e); end
        step();
        rn_in = 4'b1111;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_policy_and_race_hold();
        test_race_random();
        test_filter();
        test_async_reset_mid_filter();
        test_nand();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ttl_rsff_bank.md
Name: ttl_rsff_bank

Overview:
- Parametrised bank of CH independent R-S latches.
- Emulates SN7402 NOR-loop latches (active-high inputs) or SN74279 NAND latches (active-low inputs) in synchronous logic, clocked by the fast drive clock.
- Adds what the single-latch cell lacks: a configurable illegal-input policy, race resolution when both inputs release together, an optional per-input glitch filter, and registered edge pulses.
- Used by discrete-logic game cores wherever several latches share one drive clock (score and serve latches, coin latches).

Parameters:
- CH, 4, number of latch channels (1..16).
- ACTIVE_LOW, 0, 0 = NOR style (R/S active-high); 1 = NAND/74279 style (R_N/S_N active-low; inputs are inverted internally).
- ILLEGAL, 0, policy while both inputs are asserted: 0 HOLD, 1 SET_DOM, 2 RST_DOM, 3 NOR_TRUE (Q=0 and Q_N=0).
- RACE_MODE, 0, state after both inputs release on the same edge: 0 keep stored Q, 1 take the next LFSR bit.
- FILT, 0, glitch-filter length in clocks; 0 = bypass (combinational path).
- INIT, {CH{1'b0}}, per-channel reset value of Q.

Ports:
- CLK_DRV  in  1  drive clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- R  in  CH  per-channel reset inputs; polarity set by ACTIVE_LOW.
- S  in  CH  per-channel set inputs; polarity set by ACTIVE_LOW.
- Q  out  CH  latch outputs.
- Q_N  out  CH  complementary outputs.
- Q_RISE  out  CH  one-clock pulse after Q goes 0->1 (registered).
- Q_FALL  out  CH  one-clock pulse after Q goes 1->0 (registered).
- RACE  out  CH  one-clock pulse when a race was resolved on that channel.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - stored state dq = INIT; filter state = idle inputs, counters 0.
  - Q_RISE, Q_FALL, RACE = 0; LFSR = 16'hACE1.
  - Q and Q_N follow the combinational rules below, evaluated from dq and the filtered inputs.
- Normalisation: r = R ^ ACTIVE_LOW, s = S ^ ACTIVE_LOW, per bit.
- Filter, FILT=0: rf = r, sf = s (wires).
- Filter, FILT>0, separately per input bit:
  - 4-bit counter runs while the raw bit differs from the filtered bit; it clears when they match.
  - On the edge where the raw bit has differed for FILT consecutive samples, the filtered bit takes the raw value and the counter clears.
  - A pulse shorter than FILT clocks never reaches the latch.
- Combinational output per channel:
  - rf^sf: Q = sf.
  - rf&sf: Q per ILLEGAL. HOLD -> dq; SET_DOM -> 1; RST_DOM -> 0; NOR_TRUE -> 0.
  - neither asserted: Q = dq.
  - Q_N = ~Q, except NOR_TRUE with rf&sf, where Q_N = 0.
- Sequential update each edge: dq <= Q, with one exception for races.
  - Race condition: the previous filtered pair was (1,1) and the current pair is (0,0).
  - On that edge dq <= dq when RACE_MODE=0, or lfsr[ch] when RACE_MODE=1. RACE[ch] pulses for one clock.
  - Under NOR_TRUE the stored dq stays 0 during the illegal phase, so only the resolution decides the final state.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock. Channel ch uses bit ch mod 16.
- Edge pulses: register Q as qd. Q_RISE = Q & ~qd and Q_FALL = ~Q & qd, both registered, so a pulse appears 1 clock after Q changes.
- Latency:
  - FILT=0: Q responds in the same cycle as the input change, as in the single-latch cell.
  - FILT>0: Q responds FILT edges after the change.
- Reset asserted mid-filter or mid-illegal: all state clears immediately. After release, inputs still held asserted act normally on the next evaluation.

Decomposition:
- Package ttl_latch_pkg holds:
  - illegal_policy_e (HOLD, SET_DOM, RST_DOM, NOR_TRUE) and race_mode_e (RACE_HOLD, RACE_RAND).
  - LFSR_SEED = 16'hACE1 and the LFSR tap mask.
- Sub-module rsff_chan: one channel, containing the filter pair, policy logic, dq, race detection and edge pulses.
- The top instantiates CH copies with a generate loop and owns the shared LFSR.

Test Plan:
- Reset default: CH=4, INIT=4'b0101, hold RST_N=0 with inputs idle -> Q=0101, Q_N=1010, all pulses 0. S[1]=1 for 1 clk -> Q[1]=1 in the same cycle; Q_RISE[1] on the next clk.
- Policy sweep: ILLEGAL=0..3, dq=1, assert R=S=1 -> Q = 1/1/0/0; Q_N = 0/0/1/0.
- Race release: R=S=1 for 3 clks, then both 0 on one edge.
  - RACE_MODE=0 -> Q keeps its prior value; RACE pulses 1 clk.
  - RACE_MODE=1 -> Q equals LFSR bit ch, checked against a reference model seeded with ACE1.
- Filter: FILT=3. S pulses of 2 clks -> Q unchanged. A 3-clk pulse -> Q=1 exactly 3 edges after S rises.
- NAND mode: ACTIVE_LOW=1, drive S=4'b1110 -> Q[0]=1, other channels hold.
- Async reset mid-filter: FILT=3, S high for 2 clks, then RST_N low between edges -> Q = INIT immediately; after release Q stays INIT until 3 more stable clks.
